// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - machine timer (mtime/mtimecmp) and gated one-shot interrupt request source
// Optional software interrupt register enabled by defining TIMER_IRQ_MSIP_EN.
module timer_irq #(
  parameter int unsigned PRESCALE      = 1,
  parameter logic [63:0] MTIME_ADDR    = 64'h0200_BFF8,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0200_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [63:0] waddr_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] raddr_i,
  output logic [63:0] rdata_o,
  input  logic [63:0] csr_mstatus,
  input  logic [63:0] csr_mie,
  input  logic        irq_ack_i,
  output logic        irq_o,
  output logic [63:0] irq_cause_o,
  output logic [63:0] mtime_o
);

  localparam logic [63:0] MSIP_ADDR  = 64'h0200_0000;
  localparam logic [63:0] CAUSE_MTI  = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_MSI  = 64'h8000_0000_0000_0003;
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_CLR} state_e;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        mtip_q, mtip_d;
  logic        irq_q, irq_d;
  logic [63:0] cause_q, cause_d;
  logic        tick, wr_mtime, wr_cmp;
  logic        msip, en, sw_en, req;
  logic [63:0] req_cause;
  logic        unused_csr;

  assign unused_csr = ^{csr_mstatus[63:4], csr_mstatus[2:0], csr_mie[63:8], csr_mie[6:4], csr_mie[2:0]};

`ifdef TIMER_IRQ_MSIP_EN
  logic msip_q, msip_d;

  always_comb begin
    msip_d = msip_q;
    if (we_i && (waddr_i == MSIP_ADDR)) msip_d = wdata_i[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) msip_q <= 1'b0;
    else      msip_q <= msip_d;
  end

  assign msip = msip_q;
`else
  assign msip = 1'b0;
`endif

  always_comb begin
    tick       = (presc_q == PRESC_LAST);
    wr_mtime   = we_i && (waddr_i == MTIME_ADDR);
    wr_cmp     = we_i && (waddr_i == MTIMECMP_ADDR);
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    // A software write to mtime wins over the increment and restarts the prescale period.
    if (wr_mtime) begin
      mtime_d = wdata_i;
      presc_d = 16'd0;
    end
    mtimecmp_d = wr_cmp ? wdata_i : mtimecmp_q;
    mtip_d     = (mtime_q >= mtimecmp_q);
    rdata_d    = 64'd0;
    if (raddr_i == MTIME_ADDR)         rdata_d = mtime_q;
    else if (raddr_i == MTIMECMP_ADDR) rdata_d = mtimecmp_q;
    else if (raddr_i == MSIP_ADDR)     rdata_d = {63'd0, msip};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      rdata_q    <= 64'd0;
      mtip_q     <= 1'b0;
      irq_q      <= 1'b0;
      cause_q    <= 64'd0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      mtip_q     <= mtip_d;
      irq_q      <= irq_d;
      cause_q    <= cause_d;
    end
  end

  assign en        = csr_mstatus[3] & csr_mie[7] & mtip_q;
  assign sw_en     = csr_mstatus[3] & csr_mie[3] & msip;
  assign req       = en | sw_en;
  assign req_cause = sw_en ? CAUSE_MSI : CAUSE_MTI;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req) state_d = S_REQ;
      S_REQ: begin
        if (irq_ack_i) state_d = S_WAIT_CLR;
        else if (!req) state_d = S_IDLE;
      end
      // Held until the match condition is gone so one match yields one request.
      S_WAIT_CLR: if (!mtip_q && !msip) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    irq_d   = 1'b0;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          irq_d   = 1'b1;
          cause_d = req_cause;
        end
      end
      S_REQ: begin
        if (irq_ack_i) begin
          irq_d = 1'b0;
        end else if (!req) begin
          cause_d = 64'd0;
        end else begin
          irq_d   = 1'b1;
          cause_d = req_cause;
        end
      end
      default: irq_d = 1'b0;
    endcase
  end

  assign rdata_o     = rdata_q;
  assign irq_o       = irq_q;
  assign irq_cause_o = cause_q;
  assign mtime_o     = mtime_q;

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - self-checking bench for timer_irq (PRESCALE=1 and PRESCALE=4 instances)
module tb_timer_irq;

  localparam logic [63:0] MTIME_ADDR    = 64'h0200_BFF8;
  localparam logic [63:0] MTIMECMP_ADDR = 64'h0200_4000;
  localparam logic [63:0] MSIP_ADDR     = 64'h0200_0000;
  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_MSI     = 64'h8000_0000_0000_0003;
  localparam logic [63:0] ONES          = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef TIMER_IRQ_MSIP_EN
  localparam logic [63:0] MSIP_RD = 64'd1;
`else
  localparam logic [63:0] MSIP_RD = 64'd0;
`endif
  localparam int NV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we_a, we_b, irq_ack;
  logic [63:0] waddr, wdata, raddr, mstatus, mie;
  logic [63:0] rdata_a, rdata_b, cause_a, cause_b, mtime_a, mtime_b;
  logic        irq_a, irq_b;

  timer_irq #(.PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .we_i(we_a), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_a), .csr_mstatus(mstatus), .csr_mie(mie),
    .irq_ack_i(irq_ack), .irq_o(irq_a), .irq_cause_o(cause_a), .mtime_o(mtime_a)
  );

  timer_irq #(.PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .we_i(we_b), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_b), .csr_mstatus(mstatus), .csr_mie(mie),
    .irq_ack_i(irq_ack), .irq_o(irq_b), .irq_cause_o(cause_b), .mtime_o(mtime_b)
  );

  typedef struct {
    logic        we;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [63:0] raddr;
    logic        use_mt;
    logic [63:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_t;

  vec_t        vecs[NV];
  sb_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] mt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (!r) mt = 64'd0;
    else    mt = mt + 64'd1;
  endtask

  task automatic wait_irq(input int limit, output int n);
    n = 0;
    while (irq_a !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sb_t e;
    int  n;
    int  bad;

    vecs[0] = '{1'b0, 64'd0,            64'd0,     MTIMECMP_ADDR, 1'b0, ONES,     "rd mtimecmp reset"};
    vecs[1] = '{1'b0, 64'd0,            64'd0,     MSIP_ADDR,     1'b0, 64'd0,    "rd msip reset"};
    vecs[2] = '{1'b0, 64'd0,            64'd0,     64'hDEAD_0000, 1'b0, 64'd0,    "rd unmapped"};
    vecs[3] = '{1'b0, 64'd0,            64'd0,     MTIME_ADDR,    1'b1, 64'd0,    "rd mtime"};
    vecs[4] = '{1'b1, MTIMECMP_ADDR,    64'd1000,  MTIMECMP_ADDR, 1'b0, ONES,     "rd old during write"};
    vecs[5] = '{1'b0, 64'd0,            64'd0,     MTIMECMP_ADDR, 1'b0, 64'd1000, "rd mtimecmp new"};
    vecs[6] = '{1'b1, 64'h0200_0008,    64'd5,     MTIMECMP_ADDR, 1'b0, 64'd1000, "unmapped write ignored"};
    vecs[7] = '{1'b1, MSIP_ADDR,        64'd1,     MTIMECMP_ADDR, 1'b0, 64'd1000, "msip write"};
    vecs[8] = '{1'b0, 64'd0,            64'd0,     MSIP_ADDR,     1'b0, MSIP_RD,  "rd msip after write"};
    vecs[9] = '{1'b1, MSIP_ADDR,        64'd0,     MTIME_ADDR,    1'b1, 64'd0,    "rd mtime again"};

    rst = 1'b0; we_a = 1'b0; we_b = 1'b0; irq_ack = 1'b0;
    waddr = '0; wdata = '0; raddr = '0; mstatus = '0; mie = '0; mt = '0;
    repeat (3) step();
    chk("reset mtime_a", mtime_a, 64'd0);
    chk("reset mtime_b", mtime_b, 64'd0);
    chk("reset irq", 64'(irq_a), 64'd0);
    chk("reset cause", cause_a, 64'd0);
    chk("reset rdata", rdata_a, 64'd0);

    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("count mtime", mtime_a, 64'(i));
    end

    for (int i = 0; i < NV; i++) begin
      we_a  = vecs[i].we;
      waddr = vecs[i].waddr;
      wdata = vecs[i].wdata;
      raddr = vecs[i].raddr;
      sb.push_back('{vecs[i].name, vecs[i].use_mt ? mt : vecs[i].exp});
      step();
      we_a = 1'b0;
      e = sb.pop_front();
      chk(e.name, rdata_a, e.exp);
    end
    chk("no irq while disabled", 64'(irq_a), 64'd0);

    // Timer fire at mtimecmp=20
    waddr = MTIMECMP_ADDR; wdata = 64'd20; we_a = 1'b1;
    mstatus = 64'h8; mie = 64'h80;
    step();
    we_a = 1'b0;
    chk("pre-fire irq", 64'(irq_a), 64'd0);
    wait_irq(50, n);
    chk("fire mtime", mtime_a, 64'd22);
    chk("fire cause", cause_a, CAUSE_MTI);
    bad = 0;
    repeat (5) begin step(); if (irq_a !== 1'b1) bad++; end
    chk("irq held until ack", 64'(bad), 64'd0);

    // Acknowledge: one request per match
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("ack drops irq", 64'(irq_a), 64'd0);
    chk("cause kept after ack", cause_a, CAUSE_MTI);
    bad = 0;
    repeat (100) begin step(); if (irq_a !== 1'b0) bad++; end
    chk("single request per match", 64'(bad), 64'd0);

    waddr = MTIMECMP_ADDR; wdata = mt + 64'd10; we_a = 1'b1;
    step();
    we_a = 1'b0;
    wait_irq(40, n);
    chk("rearm latency", 64'(n + 1), 64'd12);
    chk("rearm cause", cause_a, CAUSE_MTI);

    // Withdrawal and re-raise
    mstatus = 64'h0; step();
    chk("withdraw irq", 64'(irq_a), 64'd0);
    chk("withdraw cause", cause_a, 64'd0);
    step();
    chk("withdraw stays low", 64'(irq_a), 64'd0);
    mstatus = 64'h8; step();
    chk("re-raise irq", 64'(irq_a), 64'd1);

    // Ack wins over en falling in the same cycle
    irq_ack = 1'b1; mstatus = 64'h0; step(); irq_ack = 1'b0;
    chk("ack priority irq", 64'(irq_a), 64'd0);
    chk("ack priority cause", cause_a, CAUSE_MTI);
    mstatus = 64'h8;
    bad = 0;
    repeat (10) begin step(); if (irq_a !== 1'b0) bad++; end
    chk("wait_clr holds", 64'(bad), 64'd0);

    // Reset in the middle of a request
    waddr = MTIMECMP_ADDR; wdata = mt + 64'd2; we_a = 1'b1;
    step();
    we_a = 1'b0;
    wait_irq(20, n);
    chk("request before reset", 64'(irq_a), 64'd1);
    rst = 1'b0; step(); rst = 1'b1;
    chk("reset mid-request irq", 64'(irq_a), 64'd0);
    chk("reset mid-request mtime", mtime_a, 64'd0);

`ifdef TIMER_IRQ_MSIP_EN
    mie = 64'h88;
    waddr = MSIP_ADDR; wdata = 64'd1; we_a = 1'b1; step();
    waddr = MTIMECMP_ADDR; wdata = 64'd0; step();
    we_a = 1'b0;
    step();
    chk("msip irq", 64'(irq_a), 64'd1);
    chk("msip cause priority", cause_a, CAUSE_MSI);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("msip ack", 64'(irq_a), 64'd0);
    waddr = MSIP_ADDR; wdata = 64'd0; we_a = 1'b1; step(); we_a = 1'b0;
    bad = 0;
    repeat (10) begin step(); if (irq_a !== 1'b0) bad++; end
    chk("wait_clr until mtip clears", 64'(bad), 64'd0);
    waddr = MTIMECMP_ADDR; wdata = ONES; we_a = 1'b1; step(); we_a = 1'b0;
    bad = 0;
    repeat (5) begin step(); if (irq_a !== 1'b0) bad++; end
    chk("idle after both clear", 64'(bad), 64'd0);
    mie = 64'h80;
`endif

    // PRESCALE=4: write override, increment spacing and wrap
    waddr = MTIME_ADDR; wdata = 64'hFFFF_FFFF_FFFF_FFFE; we_b = 1'b1;
    step();
    we_b = 1'b0;
    chk("b write", mtime_b, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (3) step();
    chk("b hold", mtime_b, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    chk("b increment", mtime_b, ONES);
    repeat (4) step();
    chk("b wrap", mtime_b, 64'd0);
    repeat (3) step();
    chk("b before tick", mtime_b, 64'd0);
    waddr = MTIME_ADDR; wdata = 64'h1234_5678_9ABC_DEF0; we_b = 1'b1;
    step();
    we_b = 1'b0;
    chk("b override on tick", mtime_b, 64'h1234_5678_9ABC_DEF0);
    repeat (3) step();
    chk("b prescaler cleared", mtime_b, 64'h1234_5678_9ABC_DEF0);
    step();
    chk("b next increment", mtime_b, 64'h1234_5678_9ABC_DEF1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
- Machine-mode timer and interrupt-request source. Sits directly upstream of the interrupt controller.
- Holds the 64-bit mtime and mtimecmp registers, memory-mapped on the core's data bus.
- Raises a gated, level interrupt request that drives the controller's global_int_en_i, and supplies the matching mcause value.
- Consumes the controller's acknowledge so one compare match produces exactly one request.

Parameters:
- PRESCALE, 1, clk cycles per mtime increment; legal range 1..65535.
- MTIME_ADDR, 64'h0200_BFF8, bus address of mtime.
- MTIMECMP_ADDR, 64'h0200_4000, bus address of mtimecmp.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-low reset
- we_i  input  1  bus write enable
- waddr_i  input  64  bus write address
- wdata_i  input  64  bus write data; full 64-bit writes only, no byte strobes
- raddr_i  input  64  bus read address
- rdata_o  output  64  read data, registered
- csr_mstatus  input  64  bit 3 is MIE
- csr_mie  input  64  bit 7 is MTIE, bit 3 is MSIE
- irq_ack_i  input  1  one-cycle pulse from the interrupt controller when it takes the trap
- irq_o  output  1  interrupt request to the controller
- irq_cause_o  output  64  mcause value for the pending request
- mtime_o  output  64  current mtime, for the time CSR

Behaviour:
- Reset (rst==0 at a clk edge):
  - mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - rdata_o=0, irq_o=0, irq_cause_o=0, state=S_IDLE.
  - Reset asserted mid-request drops irq_o on the following edge.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - mtime increments on the cycle the prescaler equals PRESCALE-1.
  - PRESCALE=1 means mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0 with no flag.
- Writes (we_i==1):
  - waddr_i==MTIME_ADDR: mtime takes wdata_i on the next edge. The write overrides that cycle's increment, and the prescaler clears to 0.
  - waddr_i==MTIMECMP_ADDR: mtimecmp takes wdata_i.
  - Any other address: ignored.
- Reads:
  - rdata_o is updated every cycle from raddr_i, giving 1-cycle latency.
  - Unmapped addresses return 0.
  - A read and write of the same register in the same cycle returns the old value.
- Match: mtip is a register set each cycle to (mtime >= mtimecmp), unsigned 64-bit compare. It is evaluated on the current register values, so it lags by one cycle.
- Enable: en = csr_mstatus[3] & csr_mie[7] & mtip.
- State machine (states S_IDLE, S_REQ, S_WAIT_CLR):
  - S_IDLE: if en, go to S_REQ; irq_o=1 and irq_cause_o=64'h8000_0000_0000_0007 on the next edge.
  - S_REQ:
    - irq_o held at 1.
    - If irq_ack_i arrives: go to S_WAIT_CLR, irq_o=0.
    - Else if en falls (mtimecmp rewritten, or MIE/MTIE cleared): go to S_IDLE, irq_o=0, irq_cause_o=0.
    - irq_ack_i takes priority when it coincides with en falling.
  - S_WAIT_CLR:
    - irq_o=0; irq_cause_o keeps its value.
    - Return to S_IDLE only once mtip==0.
    - This guarantees a single request per match; software must advance mtimecmp.
- irq_ack_i arriving in S_IDLE or S_WAIT_CLR is ignored.
- irq_o never asserts while csr_mstatus[3]==0.

Optional Feature:
- Macro TIMER_IRQ_MSIP_EN.
- When defined:
  - Adds a 1-bit msip register at address 64'h0200_0000; write bit 0, read zero-extended; reset value 0.
  - Software request term sw_en = csr_mstatus[3] & csr_mie[3] & msip.
  - The FSM enters S_REQ on (sw_en | en).
  - irq_cause_o=64'h8000_0000_0000_0003 when sw_en is set, since software has priority over timer. Otherwise the timer cause applies.
  - S_WAIT_CLR exits when both msip==0 and mtip==0.
- When undefined:
  - No msip register; address 64'h0200_0000 reads 0 and ignores writes.
  - Only the timer source exists.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release -> mtime counts 0,1,2,... with PRESCALE=1. Reading MTIMECMP_ADDR returns 64'hFFFF_FFFF_FFFF_FFFF one cycle after the request. irq_o stays 0.
- Timer fire: write mtimecmp=20, mstatus[3]=1, mie[7]=1 -> irq_o rises two edges after mtime reaches 20. irq_cause_o=64'h8000_0000_0000_0007. irq_o stays high until irq_ack_i.
- Single request per match: pulse irq_ack_i with mtimecmp unchanged -> irq_o=0 next cycle and stays 0 for 100 cycles. Write mtimecmp=mtime+10 -> irq_o reasserts about 12 cycles later.
- Withdrawal: in S_REQ, clear mstatus[3] -> irq_o=0 next edge, state S_IDLE. Setting MIE again re-raises irq_o.
- Write override and wrap: PRESCALE=4, write mtime=64'hFFFF_FFFF_FFFF_FFFE -> value 64'hFFFF_FFFF_FFFF_FFFF after 4 cycles, then 0 after 8 cycles. A write coinciding with an increment loads wdata exactly.
- Software interrupt (TIMER_IRQ_MSIP_EN): write msip=1 with a timer match also pending -> irq_cause_o=64'h8000_0000_0000_0003. Ack, then clear msip -> stays in S_WAIT_CLR until mtip also clears.
